// File: rtl/shift_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_ram_pkg
// Description : Load-mode encodings shared by shift_ram and its controller.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_ram_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'd0,
        MODE_LOAD  = 2'd1,
        MODE_SHIFT = 2'd2,
        MODE_WRITE = 2'd3
    } mode_t;

endpackage : shift_ram_pkg
`default_nettype wire

// File: rtl/shift_ram_if.sv
`default_nettype none
// ============================================================================
// Module      : shift_ram_if
// Description : Command, data and status bundle of the shift_ram buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface shift_ram_if
    import shift_ram_pkg::*;
#(
    parameter int SIZE  = 16,
    parameter int DEPTH = 8
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic                    clr;
    logic                    en;
    mode_t                   mode;
    logic [SIZE*DEPTH-1:0]   par_in;
    logic [SIZE-1:0]         ser_in;
    logic [ADDR_W-1:0]       wr_addr;
    logic [ADDR_W-1:0]       rd_addr;
    logic [SIZE*DEPTH-1:0]   par_out;
    logic [SIZE-1:0]         rd_data;
    logic [SIZE-1:0]         shift_out;
    logic                    shift_out_valid;
    logic [ADDR_W:0]         count;
    logic                    full;
    logic                    empty;
    logic                    err;

    modport master (
        output clr, en, mode, par_in, ser_in, wr_addr, rd_addr,
        input  par_out, rd_data, shift_out, shift_out_valid, count, full, empty, err
    );

    modport slave (
        input  clr, en, mode, par_in, ser_in, wr_addr, rd_addr,
        output par_out, rd_data, shift_out, shift_out_valid, count, full, empty, err
    );

endinterface : shift_ram_if
`default_nettype wire

// File: rtl/shift_ram.sv
`default_nettype none
// ============================================================================
// Module      : shift_ram
// Description : DEPTH x SIZE register bank with load/shift/write modes,
//               fill count, registered read port and shift-out port.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_ram
    import shift_ram_pkg::*;
#(
    parameter int SIZE  = 16,
    parameter int DEPTH = 8
)(
    input  logic        clk,
    input  logic        rst,
    shift_ram_if.slave  bus
);

    localparam int              ADDR_W  = $clog2(DEPTH);
    localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(DEPTH);

    logic [SIZE-1:0] r_mem [DEPTH];
    logic [ADDR_W:0] r_count;
    logic [SIZE-1:0] r_rd_data;
    logic [SIZE-1:0] r_shift_out;
    logic            r_shift_out_valid;
    logic            r_err;

    logic            w_rd_ok;
    logic            w_wr_ok;

    // DEPTH need not be a power of two, so addresses can exceed the array
    assign w_rd_ok = ({1'b0, bus.rd_addr} < c_DEPTH);
    assign w_wr_ok = ({1'b0, bus.wr_addr} < c_DEPTH);

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_count           <= '0;
            r_rd_data         <= '0;
            r_shift_out       <= '0;
            r_shift_out_valid <= 1'b0;
            r_err             <= 1'b0;
        end else begin
            r_rd_data         <= w_rd_ok ? r_mem[bus.rd_addr] : '0;
            r_shift_out_valid <= 1'b0;
            r_err             <= 1'b0;
            if (bus.clr) begin
                for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
                r_count <= '0;
            end else begin
                r_err <= !w_rd_ok;
                if (bus.en) begin
                    case (bus.mode)
                        MODE_LOAD: begin
                            for (int i = 0; i < DEPTH; i++)
                                r_mem[i] <= bus.par_in[i*SIZE +: SIZE];
                            r_count <= c_DEPTH;
                        end
                        MODE_SHIFT: begin
                            r_mem[0] <= bus.ser_in;
                            for (int i = 1; i < DEPTH; i++) r_mem[i] <= r_mem[i-1];
                            if (r_count == c_DEPTH) begin
                                r_shift_out       <= r_mem[DEPTH-1];
                                r_shift_out_valid <= 1'b1;
                            end else begin
                                r_count <= r_count + 1'b1;
                            end
                        end
                        MODE_WRITE: begin
                            if (w_wr_ok) r_mem[bus.wr_addr] <= bus.ser_in;
                            else         r_err <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_pack
        assign bus.par_out[g*SIZE +: SIZE] = r_mem[g];
    end

    assign bus.rd_data         = r_rd_data;
    assign bus.shift_out       = r_shift_out;
    assign bus.shift_out_valid = r_shift_out_valid;
    assign bus.count           = r_count;
    assign bus.full            = (r_count == c_DEPTH);
    assign bus.empty           = (r_count == '0);
    assign bus.err             = r_err;

endmodule : shift_ram
`default_nettype wire

// File: tb/tb_shift_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_ram
// Description : Directed self-checking bench for shift_ram (DEPTH 8 and 6).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_ram;
    import shift_ram_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    shift_ram_if #(.SIZE(16), .DEPTH(8)) bus8 ();
    shift_ram_if #(.SIZE(16), .DEPTH(6)) bus6 ();

    shift_ram #(.SIZE(16), .DEPTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
    shift_ram #(.SIZE(16), .DEPTH(6)) u_dut6 (.clk(clk), .rst(rst), .bus(bus6));

    // Advance one edge; outputs are sampled 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus8.clr = 1'b0; bus8.en = 1'b0; bus8.mode = MODE_HOLD;
        bus8.par_in = '0; bus8.ser_in = '0; bus8.wr_addr = '0; bus8.rd_addr = '0;
        bus6.clr = 1'b0; bus6.en = 1'b0; bus6.mode = MODE_HOLD;
        bus6.par_in = '0; bus6.ser_in = '0; bus6.wr_addr = '0; bus6.rd_addr = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus8.en = 1'b1; bus8.mode = MODE_LOAD;
        bus8.par_in = {$urandom, $urandom, $urandom, $urandom};
        step();
        bus8.par_in = {$urandom, $urandom, $urandom, $urandom};
        step();
        checks++; if (bus8.par_out !== 128'h0) begin errors++; $display("FAIL reset_par_out got=%h exp=0", bus8.par_out); end
        checks++; if (bus8.count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus8.count); end
        checks++; if (bus8.empty !== 1'b1 || bus8.full !== 1'b0) begin errors++; $display("FAIL reset_flags empty=%b full=%b exp 1/0", bus8.empty, bus8.full); end
        checks++; if (bus8.rd_data !== 16'h0 || bus8.shift_out !== 16'h0 || bus8.shift_out_valid !== 1'b0 || bus8.err !== 1'b0)
            begin errors++; $display("FAIL reset_outs rd=%h so=%h sov=%b err=%b exp 0", bus8.rd_data, bus8.shift_out, bus8.shift_out_valid, bus8.err); end
        idle_inputs();
        rst = 1'b1;
        step();
    endtask

    task automatic test_parallel_load();
        logic [127:0] exp;
        for (int i = 0; i < 8; i++) exp[i*16 +: 16] = 16'(i + 1);
        bus8.en = 1'b1; bus8.mode = MODE_LOAD; bus8.par_in = exp; bus8.rd_addr = 3'd5;
        step();
        bus8.en = 1'b0;
        checks++; if (bus8.par_out !== exp) begin errors++; $display("FAIL load_par_out got=%h exp=%h", bus8.par_out, exp); end
        checks++; if (bus8.count !== 4'd8 || bus8.full !== 1'b1 || bus8.empty !== 1'b0)
            begin errors++; $display("FAIL load_count got=%0d full=%b empty=%b exp 8/1/0", bus8.count, bus8.full, bus8.empty); end
        checks++; if (bus8.rd_data !== 16'h0000) begin errors++; $display("FAIL load_rd_old got=%h exp=0000", bus8.rd_data); end
        step();
        checks++; if (bus8.rd_data !== 16'h0006) begin errors++; $display("FAIL load_rd5 got=%h exp=0006", bus8.rd_data); end
    endtask

    task automatic test_addressed_write();
        bus8.en = 1'b1; bus8.mode = MODE_WRITE; bus8.wr_addr = 3'd3; bus8.ser_in = 16'hBEEF; bus8.rd_addr = 3'd3;
        step();
        bus8.en = 1'b0;
        checks++; if (bus8.rd_data !== 16'h0004) begin errors++; $display("FAIL wr_rd_old got=%h exp=0004", bus8.rd_data); end
        checks++; if (bus8.par_out[3*16 +: 16] !== 16'hBEEF || bus8.par_out[2*16 +: 16] !== 16'h0003)
            begin errors++; $display("FAIL wr_entry got=%h exp=...BEEF0003...", bus8.par_out); end
        checks++; if (bus8.count !== 4'd8 || bus8.err !== 1'b0) begin errors++; $display("FAIL wr_count got=%0d err=%b exp 8/0", bus8.count, bus8.err); end
        step();
        checks++; if (bus8.rd_data !== 16'hBEEF) begin errors++; $display("FAIL wr_rd_new got=%h exp=BEEF", bus8.rd_data); end
    endtask

    task automatic test_shift_fill();
        logic [127:0] exp;
        bus8.clr = 1'b1;
        step();
        bus8.clr = 1'b0;
        checks++; if (bus8.count !== 4'd0 || bus8.empty !== 1'b1) begin errors++; $display("FAIL clr_count got=%0d empty=%b exp 0/1", bus8.count, bus8.empty); end
        for (int k = 0; k < 10; k++) begin
            bus8.en = 1'b1; bus8.mode = MODE_SHIFT; bus8.ser_in = 16'hA000 + 16'(k);
            step();
            checks++; if (bus8.count !== 4'((k + 1 > 8) ? 8 : k + 1))
                begin errors++; $display("FAIL shift_count k=%0d got=%0d exp=%0d", k, bus8.count, (k + 1 > 8) ? 8 : k + 1); end
            checks++; if (bus8.shift_out_valid !== (k >= 8))
                begin errors++; $display("FAIL shift_valid k=%0d got=%b exp=%b", k, bus8.shift_out_valid, (k >= 8)); end
            if (k >= 8) begin
                checks++; if (bus8.shift_out !== 16'hA000 + 16'(k - 8))
                    begin errors++; $display("FAIL shift_out k=%0d got=%h exp=%h", k, bus8.shift_out, 16'hA000 + 16'(k - 8)); end
            end
        end
        bus8.en = 1'b0;
        for (int i = 0; i < 8; i++) exp[i*16 +: 16] = 16'hA009 - 16'(i);
        checks++; if (bus8.par_out !== exp) begin errors++; $display("FAIL shift_par_out got=%h exp=%h", bus8.par_out, exp); end
        step();
        checks++; if (bus8.shift_out_valid !== 1'b0 || bus8.shift_out !== 16'hA001)
            begin errors++; $display("FAIL shift_hold sov=%b so=%h exp 0/A001", bus8.shift_out_valid, bus8.shift_out); end
    endtask

    task automatic test_priority();
        bus8.clr = 1'b1; bus8.en = 1'b1; bus8.mode = MODE_SHIFT; bus8.ser_in = 16'h1234; bus8.rd_addr = 3'd0;
        step();
        checks++; if (bus8.par_out !== 128'h0 || bus8.count !== 4'd0 || bus8.shift_out_valid !== 1'b0)
            begin errors++; $display("FAIL clr_prio par=%h cnt=%0d sov=%b exp 0/0/0", bus8.par_out, bus8.count, bus8.shift_out_valid); end
        checks++; if (bus8.rd_data !== 16'hA009) begin errors++; $display("FAIL clr_rd got=%h exp=A009", bus8.rd_data); end
        bus8.clr = 1'b0; bus8.mode = MODE_LOAD; bus8.par_in = {8{16'h5A5A}};
        step();
        checks++; if (bus8.count !== 4'd8) begin errors++; $display("FAIL reload_count got=%0d exp=8", bus8.count); end
        rst = 1'b0; bus8.clr = 1'b1; bus8.mode = MODE_LOAD;
        step();
        rst = 1'b1; bus8.clr = 1'b0; bus8.en = 1'b0;
        checks++; if (bus8.par_out !== 128'h0 || bus8.count !== 4'd0 || bus8.rd_data !== 16'h0 || bus8.shift_out !== 16'h0 || bus8.empty !== 1'b1)
            begin errors++; $display("FAIL rst_prio par=%h cnt=%0d rd=%h so=%h empty=%b", bus8.par_out, bus8.count, bus8.rd_data, bus8.shift_out, bus8.empty); end
    endtask

    task automatic test_depth6();
        logic [95:0] exp;
        for (int i = 0; i < 6; i++) exp[i*16 +: 16] = 16'h0010 + 16'(i);
        bus6.en = 1'b1; bus6.mode = MODE_LOAD; bus6.par_in = exp;
        step();
        checks++; if (bus6.count !== 3'd6 || bus6.full !== 1'b1) begin errors++; $display("FAIL d6_load count=%0d full=%b exp 6/1", bus6.count, bus6.full); end
        bus6.mode = MODE_WRITE; bus6.wr_addr = 3'd7; bus6.ser_in = 16'hDEAD;
        step();
        bus6.en = 1'b0;
        checks++; if (bus6.err !== 1'b1) begin errors++; $display("FAIL d6_wr_err got=%b exp=1", bus6.err); end
        checks++; if (bus6.par_out !== exp || bus6.count !== 3'd6) begin errors++; $display("FAIL d6_nochange par=%h cnt=%0d exp %h/6", bus6.par_out, bus6.count, exp); end
        step();
        checks++; if (bus6.err !== 1'b0) begin errors++; $display("FAIL d6_err_pulse got=%b exp=0", bus6.err); end
        bus6.rd_addr = 3'd6;
        step();
        checks++; if (bus6.err !== 1'b1 || bus6.rd_data !== 16'h0) begin errors++; $display("FAIL d6_rd_oob err=%b rd=%h exp 1/0000", bus6.err, bus6.rd_data); end
        bus6.rd_addr = 3'd5;
        step();
        checks++; if (bus6.err !== 1'b0 || bus6.rd_data !== 16'h0015) begin errors++; $display("FAIL d6_rd5 err=%b rd=%h exp 0/0015", bus6.err, bus6.rd_data); end
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        test_reset();
        test_parallel_load();
        test_addressed_write();
        test_shift_fill();
        test_priority();
        test_depth6();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_shift_ram
`default_nettype wire
